// File: rtl/lsq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsq_pkg : shared LSQ / D-cache types for the D-cache port arbiter          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package lsq_pkg;

  localparam int LSQ_ADDR_WIDTH   = 26;
  localparam int LSQ_DATA_WIDTH   = 32;
  localparam int LSQ_IDX_WIDTH    = 3;
  localparam int LSQ_STARVE_LIMIT = 4;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_action_t;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_MISS_WAIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [LSQ_ADDR_WIDTH-1:0] addr;
    logic [LSQ_DATA_WIDTH-1:0] data;
    logic [LSQ_IDX_WIDTH-1:0]  idx;
    mem_action_t               action;
  } lsq_req_t;

endpackage
`default_nettype wire

// File: rtl/lsq_dcache_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsq_dcache_port_arbiter_if : LSQ-head requests and D-cache port bundle     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface lsq_dcache_port_arbiter_if
  import lsq_pkg::*;
#(
  parameter int ADDR_WIDTH = LSQ_ADDR_WIDTH,
  parameter int DATA_WIDTH = LSQ_DATA_WIDTH,
  parameter int IDX_WIDTH  = LSQ_IDX_WIDTH
) ();

  logic                  st_req;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic [IDX_WIDTH-1:0]  st_idx;
  logic                  ld_req;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [IDX_WIDTH-1:0]  ld_idx;
  logic                  flush;
  logic                  dc_miss;
  logic [DATA_WIDTH-1:0] dc_rdata;

  logic                  dc_valid;
  mem_action_t           dc_action;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic [DATA_WIDTH-1:0] dc_wdata;
  logic                  st_done;
  logic [IDX_WIDTH-1:0]  st_done_idx;
  logic                  ld_done;
  logic [IDX_WIDTH-1:0]  ld_done_idx;
  logic [DATA_WIDTH-1:0] ld_rdata;
  logic                  busy;

  // Environment side: queue heads and the D-cache.
  modport master (
    output st_req, st_addr, st_data, st_idx, ld_req, ld_addr, ld_idx,
    output flush, dc_miss, dc_rdata,
    input  dc_valid, dc_action, dc_addr, dc_wdata,
    input  st_done, st_done_idx, ld_done, ld_done_idx, ld_rdata, busy
  );

  modport slave (
    input  st_req, st_addr, st_data, st_idx, ld_req, ld_addr, ld_idx,
    input  flush, dc_miss, dc_rdata,
    output dc_valid, dc_action, dc_addr, dc_wdata,
    output st_done, st_done_idx, ld_done, ld_done_idx, ld_rdata, busy
  );

endinterface
`default_nettype wire

// File: rtl/lsq_dcache_port_arbiter_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsq_dcache_port_arbiter_sat_counter : saturating load-starvation counter   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lsq_dcache_port_arbiter_sat_counter #(
  parameter int LIMIT = 4,
  parameter int WIDTH = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic full
);

  logic [WIDTH-1:0] count;

  assign full = (count == WIDTH'(LIMIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !full) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsq_dcache_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsq_dcache_port_arbiter : single D-cache port shared by store/load heads   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lsq_dcache_port_arbiter
  import lsq_pkg::*;
#(
  parameter int ADDR_WIDTH   = LSQ_ADDR_WIDTH,
  parameter int DATA_WIDTH   = LSQ_DATA_WIDTH,
  parameter int IDX_WIDTH    = LSQ_IDX_WIDTH,
  parameter int STARVE_LIMIT = LSQ_STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lsq_dcache_port_arbiter_if.slave bus
);

  localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);

  arb_state_t            state;
  lsq_req_t              cur;
  logic                  killed;
  logic                  valid_q;

  logic                  ld_ok;
  logic                  grant_st;
  logic                  grant_ld;
  logic                  starve_full;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic                  is_idle;

  // A flushed load is simply not eligible, so a pending store can still go.
  always_comb begin
    ld_ok    = bus.ld_req && !bus.flush;
    grant_st = bus.st_req && !(ld_ok && starve_full);
    grant_ld = ld_ok && !grant_st;
    sel_addr = grant_st ? bus.st_addr : bus.ld_addr;
    sel_data = grant_st ? bus.st_data : '0;
    sel_idx  = grant_st ? bus.st_idx  : bus.ld_idx;
    is_idle  = (state == ARB_IDLE);
  end

  lsq_dcache_port_arbiter_sat_counter #(
    .LIMIT (STARVE_LIMIT),
    .WIDTH (CNT_WIDTH)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (is_idle && grant_st && bus.ld_req),
    .clr   (is_idle && grant_ld),
    .full  (starve_full)
  );

  assign bus.dc_valid  = valid_q;
  assign bus.busy      = valid_q;
  assign bus.dc_action = cur.action;
  assign bus.dc_addr   = cur.addr;
  assign bus.dc_wdata  = cur.data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ARB_IDLE;
      cur             <= '0;
      killed          <= 1'b0;
      valid_q         <= 1'b0;
      bus.st_done     <= 1'b0;
      bus.st_done_idx <= '0;
      bus.ld_done     <= 1'b0;
      bus.ld_done_idx <= '0;
      bus.ld_rdata    <= '0;
    end else begin
      bus.st_done <= 1'b0;
      bus.ld_done <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (grant_st || grant_ld) begin
            cur     <= '{addr: sel_addr, data: sel_data, idx: sel_idx,
                         action: (grant_st ? WRITE : READ)};
            killed  <= 1'b0;
            valid_q <= 1'b1;
            state   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE, ARB_MISS_WAIT: begin
          if (bus.dc_miss) begin
            // A killed load still owns the port until its refill drains.
            if (bus.flush && cur.action == READ) begin
              killed <= 1'b1;
            end
            state <= ARB_MISS_WAIT;
          end else begin
            if (cur.action == WRITE) begin
              bus.st_done     <= 1'b1;
              bus.st_done_idx <= cur.idx;
            end else if (!killed && !bus.flush) begin
              bus.ld_done     <= 1'b1;
              bus.ld_done_idx <= cur.idx;
              bus.ld_rdata    <= bus.dc_rdata;
            end
            cur     <= '0;
            killed  <= 1'b0;
            valid_q <= 1'b0;
            state   <= ARB_IDLE;
          end
        end
        default: begin
          cur     <= '0;
          killed  <= 1'b0;
          valid_q <= 1'b0;
          state   <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsq_dcache_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_lsq_dcache_port_arbiter : vectors, corner sequences, random vs model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_lsq_dcache_port_arbiter;
  import lsq_pkg::*;

  localparam int LIMIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsq_dcache_port_arbiter_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .IDX_WIDTH(3)) bus ();

  lsq_dcache_port_arbiter #(
    .ADDR_WIDTH(26), .DATA_WIDTH(32), .IDX_WIDTH(3), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit st, input bit ld, input bit fl, input bit miss);
    bus.st_req  = st;
    bus.ld_req  = ld;
    bus.flush   = fl;
    bus.dc_miss = miss;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_v, m_wr, m_killed;
  logic [25:0] m_addr;
  logic [31:0] m_data;
  logic [2:0]  m_idx;
  int          m_starve;
  bit          e_sdone, e_ldone;
  logic [2:0]  e_sidx, e_lidx;
  logic [31:0] e_rdata;

  task automatic model_edge();
    e_sdone = 0;
    e_ldone = 0;
    if (!rst_n) begin
      m_v = 0; m_killed = 0; m_starve = 0;
      return;
    end
    if (!m_v) begin
      bit take_ld;
      take_ld = bus.ld_req && !bus.flush && (!bus.st_req || m_starve == LIMIT);
      if (take_ld) begin
        m_v = 1; m_wr = 0; m_addr = bus.ld_addr; m_data = 0; m_idx = bus.ld_idx;
        m_starve = 0; m_killed = 0;
      end else if (bus.st_req) begin
        m_v = 1; m_wr = 1; m_addr = bus.st_addr; m_data = bus.st_data; m_idx = bus.st_idx;
        if (bus.ld_req && m_starve < LIMIT) m_starve++;
        m_killed = 0;
      end
    end else begin
      if (bus.flush && !m_wr) m_killed = 1;
      if (!bus.dc_miss) begin
        m_v = 0;
        if (m_wr) begin
          e_sdone = 1; e_sidx = m_idx;
        end else if (!m_killed) begin
          e_ldone = 1; e_lidx = m_idx; e_rdata = bus.dc_rdata;
        end
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          st, ld, fl, miss;
    bit          valid, act, busy, sdone, ldone;
    logic [25:0] addr;
    logic [31:0] wdata;
    logic [2:0]  idx;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[10];
  mem_action_t acts[$];

  initial begin
    drive(0, 0, 0, 0);
    bus.st_addr = 26'h10; bus.st_data = 32'hDEAD; bus.st_idx = 3'd2;
    bus.ld_addr = 26'h40; bus.ld_idx = 3'd5; bus.dc_rdata = 32'h1234;

    vecs[0] = '{1,0,0,0, 1,1,1,0,0, 26'h10, 32'hDEAD, 3'd0, 32'h0};
    vecs[1] = '{0,0,0,0, 0,0,0,1,0, 26'h0,  32'h0,    3'd2, 32'h0};
    vecs[2] = '{0,0,0,0, 0,0,0,0,0, 26'h0,  32'h0,    3'd0, 32'h0};
    vecs[3] = '{0,1,0,0, 1,0,1,0,0, 26'h40, 32'h0,    3'd0, 32'h0};
    vecs[4] = '{0,1,0,1, 1,0,1,0,0, 26'h40, 32'h0,    3'd0, 32'h0};
    vecs[5] = '{0,1,0,1, 1,0,1,0,0, 26'h40, 32'h0,    3'd0, 32'h0};
    vecs[6] = '{0,1,0,1, 1,0,1,0,0, 26'h40, 32'h0,    3'd0, 32'h0};
    vecs[7] = '{0,0,0,0, 0,0,0,0,1, 26'h0,  32'h0,    3'd5, 32'h1234};
    vecs[8] = '{0,1,1,0, 0,0,0,0,0, 26'h0,  32'h0,    3'd0, 32'h0};
    vecs[9] = '{0,0,0,0, 0,0,0,0,0, 26'h0,  32'h0,    3'd0, 32'h0};

    do_reset();
    chk("reset ctl", {bus.dc_valid, bus.busy, bus.st_done, bus.ld_done}, 4'b0000);
    chk("reset bus", {bus.dc_action, bus.dc_addr, bus.dc_wdata}, 59'h0);
    chk("reset idx", {bus.st_done_idx, bus.ld_done_idx, bus.ld_rdata}, 38'h0);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].st, vecs[i].ld, vecs[i].fl, vecs[i].miss);
      tick();
      chk($sformatf("vec%0d ctl", i),
          {bus.dc_valid, bus.dc_action, bus.busy, bus.st_done, bus.ld_done},
          {vecs[i].valid, vecs[i].act, vecs[i].busy, vecs[i].sdone, vecs[i].ldone});
      if (vecs[i].valid)
        chk($sformatf("vec%0d access", i), {bus.dc_addr, bus.dc_wdata},
            {vecs[i].addr, vecs[i].wdata});
      if (vecs[i].sdone)
        chk($sformatf("vec%0d st_idx", i), bus.st_done_idx, vecs[i].idx);
      if (vecs[i].ldone)
        chk($sformatf("vec%0d ld_result", i), {bus.ld_done_idx, bus.ld_rdata},
            {vecs[i].idx, vecs[i].rdata});
    end

    // Starvation: both heads held, every access hits.
    do_reset();
    drive(1, 1, 0, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.dc_valid) acts.push_back(bus.dc_action);
    end
    chk("starve count", acts.size(), 10);
    for (int k = 0; k < 10 && k < acts.size(); k++)
      chk($sformatf("starve acc%0d", k), acts[k], (k % 5 == 4) ? READ : WRITE);

    // Flush during a load miss: port stays held, no ld_done.
    do_reset();
    drive(0, 1, 0, 0); tick();
    drive(0, 1, 0, 1); tick();
    chk("fmiss valid0", bus.dc_valid, 1'b1);
    drive(0, 1, 1, 1); tick();
    chk("fmiss valid1", bus.dc_valid, 1'b1);
    drive(0, 0, 0, 1); tick();
    chk("fmiss valid2", {bus.dc_valid, bus.ld_done}, 2'b10);
    drive(0, 0, 0, 0); tick();
    chk("fmiss end", {bus.dc_valid, bus.busy, bus.ld_done}, 3'b000);
    tick();
    chk("fmiss no done", bus.ld_done, 1'b0);

    // Flush during a store hit: store still completes.
    drive(1, 0, 0, 0); tick();
    chk("fst issue", {bus.dc_valid, bus.dc_action}, 2'b11);
    drive(0, 0, 1, 0); tick();
    chk("fst done", {bus.st_done, bus.st_done_idx}, 4'b1010);

    // Reset in the middle of a miss.
    drive(0, 1, 0, 0); tick();
    drive(0, 1, 0, 1); tick();
    drive(0, 1, 0, 1); tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 1); tick();
    chk("rstmiss outs", {bus.dc_valid, bus.busy, bus.st_done, bus.ld_done,
                         bus.dc_action, bus.dc_addr, bus.dc_wdata}, 63'h0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0); tick();
    chk("rstmiss after", {bus.dc_valid, bus.ld_done}, 2'b00);
    tick();
    chk("rstmiss after2", {bus.dc_valid, bus.ld_done}, 2'b00);

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    model_edge();
    tick();
    for (int c = 0; c < 3000; c++) begin
      rst_n        = ($urandom_range(0, 63) != 0);
      bus.st_req   = ($urandom_range(0, 99) < 60);
      bus.ld_req   = ($urandom_range(0, 99) < 60);
      bus.flush    = ($urandom_range(0, 99) < 10);
      bus.dc_miss  = ($urandom_range(0, 99) < 40);
      bus.st_addr  = 26'($urandom);
      bus.st_data  = $urandom;
      bus.st_idx   = 3'($urandom);
      bus.ld_addr  = 26'($urandom);
      bus.ld_idx   = 3'($urandom);
      bus.dc_rdata = $urandom;
      model_edge();
      tick();
      chk("rnd ctl", {bus.dc_valid, bus.busy, bus.st_done, bus.ld_done},
          {m_v, m_v, e_sdone, e_ldone});
      if (m_v)
        chk("rnd access", {bus.dc_action, bus.dc_addr, bus.dc_wdata},
            {m_wr, m_addr, (m_wr ? m_data : 32'h0)});
      if (e_sdone) chk("rnd st_idx", bus.st_done_idx, e_sidx);
      if (e_ldone) chk("rnd ld_result", {bus.ld_done_idx, bus.ld_rdata}, {e_lidx, e_rdata});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
